// File: rtl/dbg_host_pkg.sv
// ----------------------------------------------------------------------------
// dbg_host_pkg : shared states, register indices and data width for the debug
//                host controller.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dbg_host_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] DBG_REG0 = 2'd0;
  localparam logic [1:0] DBG_REG1 = 2'd1;
  localparam logic [1:0] DBG_REG2 = 2'd2;
  localparam logic [1:0] DBG_REG3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dbg_sync2.sv
// ----------------------------------------------------------------------------
// dbg_sync2 : multi-flop synchronizer for a single asynchronous level.
//             Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dbg_sync2
  import dbg_host_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Fewer than two flops gives no metastability margin, so clamp.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/dbg_host_ctrl.sv
// ----------------------------------------------------------------------------
// dbg_host_ctrl : host-side master turning single-beat commands into a 4-phase
//                 req/ack transfer on the SoC debug port.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dbg_host_ctrl
  import dbg_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [1:0]        cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [1:0]        addr,
  output logic [DATA_W-1:0] write_data,
  output logic              wr_en,
  output logic              req,
  input  logic [DATA_W-1:0] read_data,
  input  logic              ack
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             ack_s;

  dbg_sync2 #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      cmd_ready   <= 1'b1;
      req         <= 1'b0;
      wr_en       <= 1'b0;
      addr        <= '0;
      write_data  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr       <= cmd_addr;
            write_data <= cmd_wdata;
            wr_en      <= cmd_wr;
            tmo_cnt    <= '0;
            req        <= 1'b1;
            cmd_ready  <= 1'b0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            // read_data is held stable by the SoC while ack is high.
            rsp_rdata   <= wr_en ? '0 : read_data;
            rsp_timeout <= 1'b0;
            req         <= 1'b0;
            state       <= REL;
          end else if (TMO_EN && (tmo_cnt == CNT_LAST)) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            req         <= 1'b0;
            state       <= REL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        REL: begin
          if (!ack_s) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dbg_host_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dbg_host_ctrl : directed plus randomized checks of dbg_host_ctrl against a
//                    register-file reference model and a behavioural SoC port.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dbg_host_ctrl;
  import dbg_host_pkg::*;

  localparam int TMO  = 16;
  localparam int SYNC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [1:0]        cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic [1:0]        addr;
  logic [DATA_W-1:0] write_data;
  logic              wr_en;
  logic              req;
  logic [DATA_W-1:0] read_data;
  logic              ack;

  always #5 clk = ~clk;

  dbg_host_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .addr        (addr),
    .write_data  (write_data),
    .wr_en       (wr_en),
    .req         (req),
    .read_data   (read_data),
    .ack         (ack)
  );

  // SoC-side register file and its handshake behaviour.
  logic [31:0] soc_mem [4];
  int          soc_delay = 0;
  int          soc_hold  = 0;
  bit          soc_noack = 1'b0;

  // Reference register contents as the host should see them.
  logic [31:0] ref_mem [4];

  bit          nxt_pending = 1'b0;
  bit          nxt_wr      = 1'b0;
  logic [1:0]  nxt_addr    = 2'd0;
  logic [31:0] nxt_wdata   = 32'd0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    ack       = 1'b0;
    read_data = '0;
    forever begin
      @(negedge clk);
      if (req === 1'b1 && !soc_noack) begin
        repeat (soc_delay) @(negedge clk);
        if (wr_en === 1'b1) soc_mem[addr] = write_data;
        else                read_data     = soc_mem[addr];
        ack = 1'b1;
        while (req === 1'b1) @(negedge clk);
        repeat (soc_hold) @(negedge clk);
        ack       = 1'b0;
        read_data = $urandom;
      end
    end
  end

  // Issue one command and verify its handshake and response. Entered and left on a negedge.
  task automatic do_cmd(input bit wr, input logic [1:0] a, input logic [31:0] wd,
                        input bit noack, input int dly, input int hold);
    bit          acc;
    bit          done;
    bit          stable_ok;
    bit          ready_ok;
    int          req_cyc;
    int          low_cyc;
    int          exp_req;
    int          exp_low;
    logic [31:0] exp_rdata;

    soc_noack = noack;
    soc_delay = dly;
    soc_hold  = hold;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_valid = 1'b1;

    acc = 1'b0;
    for (int n = 0; n < 60 && !acc; n++) begin
      if (cmd_ready === 1'b1) acc = 1'b1;
      @(negedge clk);
    end
    check("accept", 32'(acc), 32'd1);

    if (nxt_pending) begin
      cmd_wr    = nxt_wr;
      cmd_addr  = nxt_addr;
      cmd_wdata = nxt_wdata;
    end else begin
      cmd_valid = 1'b0;
    end

    exp_rdata = (noack || wr) ? 32'd0 : ref_mem[a];
    if (!noack && wr) ref_mem[a] = wd;
    exp_req = noack ? TMO : dly + SYNC + 1;
    exp_low = noack ? 2   : hold + SYNC + 2;

    req_cyc   = 0;
    low_cyc   = 0;
    done      = 1'b0;
    stable_ok = 1'b1;
    ready_ok  = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      if (cmd_ready !== 1'b0) ready_ok = 1'b0;
      if (req === 1'b1) begin
        req_cyc++;
        if (addr !== a || write_data !== wd || wr_en !== wr) stable_ok = 1'b0;
      end else begin
        low_cyc++;
      end
      if (rsp_valid === 1'b1) done = 1'b1;
      else                    @(negedge clk);
    end

    check("rsp_seen",      32'(done),        32'd1);
    check("req_cycles",    32'(req_cyc),     32'(exp_req));
    check("rel_to_rsp",    32'(low_cyc),     32'(exp_low));
    check("port_stable",   32'(stable_ok),   32'd1);
    check("ready_low",     32'(ready_ok),    32'd1);
    check("req_at_rsp",    32'(req),         32'd0);
    check("rsp_rdata",     rsp_rdata,        exp_rdata);
    check("rsp_timeout",   32'(rsp_timeout), 32'(noack));

    @(negedge clk);
    check("rsp_one_shot",  32'(rsp_valid),   32'd0);
    check("ready_after",   32'(cmd_ready),   32'd1);
  endtask

  initial begin
    bit          flag_ok;
    bit          rwr;
    logic [1:0]  ra;
    logic [31:0] rwd;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 2'd0;
    cmd_wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      soc_mem[i] = $urandom;
      ref_mem[i] = soc_mem[i];
    end
    soc_mem[DBG_REG1] = 32'hDEADBEEF;
    ref_mem[DBG_REG1] = 32'hDEADBEEF;

    #1;
    check("rst_req",         32'(req),         32'd0);
    check("rst_wr_en",       32'(wr_en),       32'd0);
    check("rst_addr",        32'(addr),        32'd0);
    check("rst_write_data",  write_data,       32'd0);
    check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst_rsp_rdata",   rsp_rdata,        32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_cmd_ready",   32'(cmd_ready),   32'd1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Read acked three cycles after req.
    do_cmd(1'b0, DBG_REG1, 32'h0, 1'b0, 3, 0);
    // Write to register 2.
    do_cmd(1'b1, DBG_REG2, 32'h00001234, 1'b0, 2, 1);
    // No ack: timeout, then a normal read of the written register.
    do_cmd(1'b0, DBG_REG3, 32'h0, 1'b1, 0, 0);
    do_cmd(1'b0, DBG_REG2, 32'h0, 1'b0, 1, 0);
    // Ack held long after req drops.
    do_cmd(1'b0, DBG_REG0, 32'h0, 1'b0, 1, 20);

    // Command held valid during a transaction, then back-to-back reads 0 and 3.
    nxt_pending = 1'b1;
    nxt_wr      = 1'b0;
    nxt_addr    = DBG_REG3;
    nxt_wdata   = 32'h0;
    do_cmd(1'b0, DBG_REG0, 32'h0, 1'b0, 2, 0);
    nxt_pending = 1'b0;
    do_cmd(1'b0, DBG_REG3, 32'h0, 1'b0, 0, 2);

    for (int k = 0; k < 24; k++) begin
      rwr = 1'($urandom_range(0, 1));
      ra  = 2'($urandom_range(0, 3));
      rwd = $urandom;
      do_cmd(rwr, ra, rwd, ($urandom_range(0, 5) == 0),
             int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
    end

    // Reset in the middle of a write that is never acked.
    soc_noack = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = DBG_REG2;
    cmd_wdata = 32'hA5A5_0F0F;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_req_high", 32'(req),   32'd1);
    check("mid_wr_en",    32'(wr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req",       32'(req),       32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_wr_en",     32'(wr_en),     32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst     = 1'b0;
    flag_ok = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || req !== 1'b0) flag_ok = 1'b0;
    end
    check("no_stale_rsp", 32'(flag_ok), 32'd1);

    do_cmd(1'b0, DBG_REG1, 32'h0, 1'b0, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
